jt12_op_seq: RTL and testbench

JT12_OP_SEQ -- requirements
Module: jt12_op_seq

---
 rtl/jt12_op_seq.sv | 115 +++++++++++
 tb/tb_jt12_op_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jt12_op_seq.sv
// Operator slot sequencer: walks the 24-slot frame (4 operators x 6 channels) and
// decodes per-channel algorithm/feedback into operand-source selects.
module jt12_op_seq #(
   parameter logic [2:0] ALG_RST = 3'd0,
   parameter logic [2:0] FB_RST  = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       cfg_we,
   input  logic [2:0] cfg_ch,
   input  logic [2:0] cfg_alg,
   input  logic [2:0] cfg_fb,
   output logic       cfg_ack,
   output logic       s1_enters,
   output logic       s2_enters,
   output logic       s3_enters,
   output logic       s4_enters,
   output logic       zero,
   output logic [2:0] cur_ch,
   output logic       xuse_prevprev1,
   output logic       xuse_prev2,
   output logic       xuse_internal,
   output logic       yuse_prev1,
   output logic       yuse_prev2,
   output logic       yuse_internal,
   output logic [2:0] fb_II
);

   logic [4:0] cnt;
   logic [1:0] grp;
   logic [2:0] alg_rf [0:5];
   logic [2:0] fb_rf  [0:5];
   logic [4:0] cnt_nx;
   logic [1:0] grp_nx;
   logic [2:0] ch_nx;
   logic       wr_ok;

   // Selects packed as {xpp1, xp2, xint, yp1, yp2, yint}; grp order is M1, C1, M2, C2
   function automatic logic [5:0] decode(input logic [1:0] g, input logic [2:0] alg);
      logic [5:0] s;
      s = 6'b000000;
      case (g)
         2'd0: s = 6'b100100;
         2'd1: if (alg != 3'd1 && alg != 3'd2 && alg != 3'd7) s = 6'b001000;
         2'd2: case (alg)
                  3'd0, 3'd2: s = 6'b001000;
                  3'd1:       s = 6'b001100;
                  3'd5:       s = 6'b000100;
                  default:    s = 6'b000000;
               endcase
         default: case (alg)
                  3'd0, 3'd1, 3'd4: s = 6'b001000;
                  3'd2:             s = 6'b001100;
                  3'd3:             s = 6'b001010;
                  3'd5:             s = 6'b000100;
                  default:          s = 6'b000000;
               endcase
      endcase
      return s;
   endfunction

   always_comb begin
      cnt_nx = (cnt == 5'd23) ? 5'd0 : cnt + 5'd1;
      ch_nx  = (cur_ch == 3'd5) ? 3'd0 : cur_ch + 3'd1;
      grp_nx = (cur_ch == 3'd5) ? grp + 2'd1 : grp;
      wr_ok  = cfg_we && (cfg_ch <= 3'd5);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) begin
            alg_rf[i] <= ALG_RST;
            fb_rf[i]  <= FB_RST;
         end
      end else if (wr_ok) begin
         alg_rf[cfg_ch] <= cfg_alg;
         fb_rf[cfg_ch]  <= cfg_fb;
      end
   end

   // Slot outputs are computed from the next counter value so they line up with cnt
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 5'd0;
         grp       <= 2'd0;
         cur_ch    <= 3'd0;
         zero      <= 1'b1;
         s1_enters <= 1'b1;
         s2_enters <= 1'b0;
         s3_enters <= 1'b0;
         s4_enters <= 1'b0;
         {xuse_prevprev1, xuse_prev2, xuse_internal,
          yuse_prev1, yuse_prev2, yuse_internal} <= decode(2'd0, ALG_RST);
         fb_II     <= 3'd0;
         cfg_ack   <= 1'b0;
      end else begin
         cfg_ack <= wr_ok;
         if (clk_en) begin
            cnt       <= cnt_nx;
            grp       <= grp_nx;
            cur_ch    <= ch_nx;
            zero      <= (cnt_nx == 5'd0);
            s1_enters <= (grp_nx == 2'd0);
            s3_enters <= (grp_nx == 2'd1);
            s2_enters <= (grp_nx == 2'd2);
            s4_enters <= (grp_nx == 2'd3);
            {xuse_prevprev1, xuse_prev2, xuse_internal,
             yuse_prev1, yuse_prev2, yuse_internal} <= decode(grp_nx, alg_rf[ch_nx]);
            fb_II     <= fb_rf[cur_ch];
         end
      end
   end

endmodule

// File: tb/tb_jt12_op_seq.sv
// Randomized and directed bench for jt12_op_seq against a slot-table reference model.
module tb_jt12_op_seq;

   logic       clk = 1'b0;
   logic       rst, clk_en, cfg_we;
   logic [2:0] cfg_ch, cfg_alg, cfg_fb;
   logic       cfg_ack, s1_enters, s2_enters, s3_enters, s4_enters, zero;
   logic [2:0] cur_ch, fb_II;
   logic       xuse_prevprev1, xuse_prev2, xuse_internal;
   logic       yuse_prev1, yuse_prev2, yuse_internal;

   jt12_op_seq dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_alg(cfg_alg), .cfg_fb(cfg_fb), .cfg_ack(cfg_ack),
      .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
      .s4_enters(s4_enters), .zero(zero), .cur_ch(cur_ch),
      .xuse_prevprev1(xuse_prevprev1), .xuse_prev2(xuse_prev2),
      .xuse_internal(xuse_internal), .yuse_prev1(yuse_prev1),
      .yuse_prev2(yuse_prev2), .yuse_internal(yuse_internal), .fb_II(fb_II)
   );

   always #5 clk = ~clk;

   // Algorithm membership sets: bit a set means algorithm a uses that source
   localparam logic [7:0] S3_XINT = 8'b0111_1001;
   localparam logic [7:0] S2_XINT = 8'b0000_0111;
   localparam logic [7:0] S2_YP1  = 8'b0010_0010;
   localparam logic [7:0] S4_XINT = 8'b0001_1111;
   localparam logic [7:0] S4_YP1  = 8'b0010_0100;
   localparam logic [7:0] S4_YP2  = 8'b0000_1000;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         mcnt;
   logic [2:0] malg [0:5];
   logic [2:0] mfb  [0:5];
   logic [13:0] mslot;
   logic [2:0] mfbii;
   logic       mack;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (model cnt %0d)", tag, got, exp, mcnt);
      end
   endtask

   // Slot word {s1,s2,s3,s4,zero,cur_ch,xpp1,xp2,xint,yp1,yp2,yint} for frame position c
   function automatic logic [13:0] slot_of(input int c, input logic [2:0] a);
      int op;
      logic xpp1, xint, yp1, yp2;
      op = c / 6;
      xpp1 = (op == 0);
      xint = (op == 1) ? S3_XINT[a] : (op == 2) ? S2_XINT[a] : (op == 3) ? S4_XINT[a] : 1'b0;
      yp1  = (op == 0) ? 1'b1 : (op == 2) ? S2_YP1[a] : (op == 3) ? S4_YP1[a] : 1'b0;
      yp2  = (op == 3) ? S4_YP2[a] : 1'b0;
      return {op == 0, op == 2, op == 1, op == 3, c == 0, 3'(c % 6),
              xpp1, 1'b0, xint, yp1, yp2, 1'b0};
   endfunction

   function automatic logic [17:0] observed();
      return {s1_enters, s2_enters, s3_enters, s4_enters, zero, cur_ch,
              xuse_prevprev1, xuse_prev2, xuse_internal, yuse_prev1, yuse_prev2,
              yuse_internal, fb_II, cfg_ack};
   endfunction

   // One clock: apply inputs, advance model with pre-edge state, compare everything
   task automatic step(input logic r, input logic en, input logic we,
                       input logic [2:0] ch, input logic [2:0] a, input logic [2:0] f);
      rst = r; clk_en = en; cfg_we = we; cfg_ch = ch; cfg_alg = a; cfg_fb = f;
      @(posedge clk);
      if (r) begin
         mcnt = 0; mfbii = 3'd0; mack = 1'b0;
         for (int i = 0; i < 6; i++) begin malg[i] = 3'd0; mfb[i] = 3'd0; end
         mslot = slot_of(0, 3'd0);
      end else begin
         mack = we && (ch < 3'd6);
         if (en) begin
            mfbii = mfb[mcnt % 6];
            mcnt  = (mcnt + 1) % 24;
            mslot = slot_of(mcnt, malg[mcnt % 6]);
         end
         if (mack) begin malg[ch] = a; mfb[ch] = f; end
      end
      #1;
      chk("outputs", 32'(observed()), 32'({mslot, mfbii, mack}));
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (mcnt != target && guard < 30) begin
         step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
         guard++;
      end
      chk("run_to_reached", 32'(mcnt), 32'(target));
   endtask

   initial begin
      int c0;
      mcnt = 0; mfbii = 3'd0; mack = 1'b0; mslot = '0;
      for (int i = 0; i < 6; i++) begin malg[i] = 3'd0; mfb[i] = 3'd0; end
      rst = 1'b1; clk_en = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_alg = 3'd0; cfg_fb = 3'd0;
      #2;
      step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("rst_s1", 32'(s1_enters), 32'd1);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_sel", 32'({xuse_prevprev1, xuse_prev2, xuse_internal,
                          yuse_prev1, yuse_prev2, yuse_internal}), 32'b100100);
      chk("rst_ack", 32'(cfg_ack), 32'd0);

      // Free run over two frames
      for (int i = 1; i <= 48; i++) begin
         step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
         if (i == 24 || i == 48) chk("frame_zero", 32'(zero), 32'd1);
         if (i == 9)  chk("c1_slot", 32'({s1_enters, s3_enters, s2_enters, s4_enters}), 32'b0100);
         if (i == 15) chk("m2_slot", 32'({s1_enters, s3_enters, s2_enters, s4_enters}), 32'b0010);
         if (i == 21) chk("c2_slot", 32'({s1_enters, s3_enters, s2_enters, s4_enters}), 32'b0001);
         if (i == 29) chk("cur_ch_seq", 32'(cur_ch), 32'd5);
      end

      // ch2 alg=3
      step(1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 3'd0);
      chk("wr_ack", 32'(cfg_ack), 32'd1);
      run_to(14);
      chk("ch2_s2_none", 32'({xuse_prevprev1, xuse_prev2, xuse_internal,
                              yuse_prev1, yuse_prev2, yuse_internal}), 32'd0);
      run_to(20);
      chk("ch2_s4_xint", 32'(xuse_internal), 32'd1);
      chk("ch2_s4_yp2", 32'(yuse_prev2), 32'd1);

      // ch0 fb=5 alg=7
      step(1'b0, 1'b1, 1'b1, 3'd0, 3'd7, 3'd5);
      run_to(0);
      step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("ch0_fb_II", 32'(fb_II), 32'd5);
      for (int k = 1; k <= 3; k++) begin
         run_to(6 * k);
         chk("ch0_alg7_none", 32'({xuse_prevprev1, xuse_prev2, xuse_internal,
                                   yuse_prev1, yuse_prev2, yuse_internal}), 32'd0);
      end

      // Illegal channel: nothing changes, verified over a full frame
      step(1'b0, 1'b1, 1'b1, 3'd6, 3'd7, 3'd7);
      chk("ch6_no_ack", 32'(cfg_ack), 32'd0);
      step(1'b0, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7);
      chk("ch7_no_ack", 32'(cfg_ack), 32'd0);
      for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);

      // clk_en 1-0-0-1 with a write while stalled
      c0 = int'(cur_ch);
      step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      step(1'b0, 1'b0, 1'b1, 3'd4, 3'd5, 3'd2);
      chk("stall_ack", 32'(cfg_ack), 32'd1);
      step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
      step(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
      chk("stall_adv2", 32'(cur_ch), 32'((c0 + 2) % 6));

      // Reset mid-frame at slot 17
      run_to(17);
      step(1'b1, 1'b1, 1'b1, 3'd1, 3'd6, 3'd6);
      chk("mid_rst_zero", 32'(zero), 32'd1);
      chk("mid_rst_ch", 32'(cur_ch), 32'd0);
      run_to(6);
      chk("rst_alg_c1", 32'(xuse_internal), 32'd1);
      run_to(22);
      chk("rst_alg_c2", 32'(xuse_internal), 32'd1);

      // Held-high write with unchanged data acknowledges every cycle
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 3'd3, 3'd2, 3'd4);
         chk("held_we_ack", 32'(cfg_ack), 32'd1);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) < 3), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
